// File: rtl/ecc_host_ctrl.sv
// rtl/ecc_host_ctrl.sv - register-mapped host sequencer for the ECC core
// Loads operands over a 32-bit word bus, runs the core and captures its x/y results.
module ecc_host_ctrl #(
    parameter logic [31:0] TIMEOUT = 32'd16000000,
    parameter int          CNT_W   = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic         rd_en,
    input  logic [5:0]   addr,
    input  logic [31:0]  wdata,
    output logic [31:0]  rdata,
    output logic         irq,
    output logic [1:0]   ecc_op,
    output logic         ecc_en,
    output logic         ecc_clr,
    output logic [255:0] in_kr,
    output logic [255:0] in_ds,
    output logic [255:0] hash_msg,
    output logic [255:0] Qx,
    output logic [255:0] Qy,
    input  logic         ecc_rdy,
    input  logic [255:0] x,
    input  logic [255:0] y
);

    typedef enum logic [1:0] {IDLE, CLR, RUN, ABORT} state_t;

    state_t             state, state_d;
    logic [255:0]       kr_q, ds_q, hash_q, qx_q, qy_q, xr_q, yr_q;
    logic [CNT_W-1:0]   cnt, cnt_inc;
    logic               done, tmo, busy;
    logic               ctrl_wr, stat_wr;
    logic               start_acc, set_done, set_tmo;
    logic [255:0]       row;
    logic [31:0]        rd_word;

    assign busy     = (state != IDLE);
    assign ecc_en   = (state == RUN);
    assign ecc_clr  = (state == CLR) || (state == ABORT);
    assign ctrl_wr  = wr_en && (addr == 6'h38);
    assign stat_wr  = wr_en && (addr == 6'h39);
    assign cnt_inc  = (cnt == '1) ? cnt : cnt + 1'b1;

    assign in_kr    = kr_q;
    assign in_ds    = ds_q;
    assign hash_msg = hash_q;
    assign Qx       = qx_q;
    assign Qy       = qy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d   = state;
        start_acc = 1'b0;
        set_done  = 1'b0;
        set_tmo   = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl_wr && wdata[0] && !wdata[3]) begin
                    start_acc = 1'b1;
                    state_d   = CLR;
                end
            end
            CLR: state_d = RUN;
            RUN: begin
                // cnt is still zero in the first RUN cycle, which masks a stale rdy
                if (ecc_rdy && (cnt != '0)) begin
                    set_done = 1'b1;
                    state_d  = IDLE;
                end else if ((TIMEOUT != 32'd0) && (32'(cnt_inc) == TIMEOUT)) begin
                    set_tmo = 1'b1;
                    state_d = ABORT;
                end else if (ctrl_wr && wdata[3]) begin
                    state_d = ABORT;
                end
            end
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        row = '0;
        case (addr[5:3])
            3'd0:    row = kr_q;
            3'd1:    row = ds_q;
            3'd2:    row = hash_q;
            3'd3:    row = qx_q;
            3'd4:    row = qy_q;
            3'd5:    row = xr_q;
            3'd6:    row = yr_q;
            default: row = '0;
        endcase
        rd_word = row[{addr[2:0], 5'b0} +: 32];
        if (addr[5:3] == 3'd7) begin
            case (addr[2:0])
                3'd1:    rd_word = {27'd0, ecc_op, tmo, done, busy};
                3'd2:    rd_word = 32'(cnt);
                default: rd_word = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kr_q   <= '0;
            ds_q   <= '0;
            hash_q <= '0;
            qx_q   <= '0;
            qy_q   <= '0;
            xr_q   <= '0;
            yr_q   <= '0;
            cnt    <= '0;
            ecc_op <= 2'd0;
            done   <= 1'b0;
            tmo    <= 1'b0;
            irq    <= 1'b0;
            rdata  <= 32'd0;
        end else begin
            if (wr_en && !busy) begin
                case (addr[5:3])
                    3'd0:    kr_q[{addr[2:0], 5'b0} +: 32]   <= wdata;
                    3'd1:    ds_q[{addr[2:0], 5'b0} +: 32]   <= wdata;
                    3'd2:    hash_q[{addr[2:0], 5'b0} +: 32] <= wdata;
                    3'd3:    qx_q[{addr[2:0], 5'b0} +: 32]   <= wdata;
                    3'd4:    qy_q[{addr[2:0], 5'b0} +: 32]   <= wdata;
                    default: ;
                endcase
            end
            if (set_done) begin
                xr_q <= x;
                yr_q <= y;
            end
            if (start_acc)           cnt <= '0;
            else if (state == RUN)   cnt <= cnt_inc;
            if (start_acc) ecc_op <= wdata[2:1];
            // W1C is checked before the set so a same-cycle clear wins
            if (start_acc)                  done <= 1'b0;
            else if (stat_wr && wdata[1])   done <= 1'b0;
            else if (set_done)              done <= 1'b1;
            if (start_acc)                  tmo <= 1'b0;
            else if (stat_wr && wdata[2])   tmo <= 1'b0;
            else if (set_tmo)               tmo <= 1'b1;
            irq <= done | tmo;
            if (rd_en) rdata <= rd_word;
        end
    end

endmodule

// File: tb/tb_ecc_host_ctrl.sv
// tb/tb_ecc_host_ctrl.sv - directed self-checking bench for ecc_host_ctrl
module tb_ecc_host_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic        sel_b = 1'b0;
    logic [5:0]  addr = 6'd0;
    logic [31:0] wdata = 32'd0;

    logic         wr_a, rd_a, wr_b, rd_b;
    logic [31:0]  rdata_a, rdata_b, rdata_s;
    logic         irq_a, irq_b, en_a, en_b, clr_a, clr_b;
    logic [1:0]   op_a, op_b;
    logic [255:0] kr_a, ds_a, hash_a, qx_a, qy_a;
    logic [255:0] kr_b, ds_b, hash_b, qx_b, qy_b;
    logic         rdy_a = 1'b0;
    logic         rdy_b = 1'b0;
    logic [255:0] x_a = '0;
    logic [255:0] y_a = '0;
    logic [255:0] x_b = '1;
    logic [255:0] y_b = '1;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    int en_hi_a = 0, clr_n_a = 0, en_hi_b = 0, clr_n_b = 0;
    int rdy_mode = 0;
    int rdy_at = 0;

    assign wr_a    = wr_en && !sel_b;
    assign rd_a    = rd_en && !sel_b;
    assign wr_b    = wr_en && sel_b;
    assign rd_b    = rd_en && sel_b;
    assign rdata_s = sel_b ? rdata_b : rdata_a;

    always #5 clk = ~clk;

    ecc_host_ctrl #(.TIMEOUT(32'd0), .CNT_W(32)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_a), .rd_en(rd_a), .addr(addr), .wdata(wdata),
        .rdata(rdata_a), .irq(irq_a), .ecc_op(op_a), .ecc_en(en_a), .ecc_clr(clr_a),
        .in_kr(kr_a), .in_ds(ds_a), .hash_msg(hash_a), .Qx(qx_a), .Qy(qy_a),
        .ecc_rdy(rdy_a), .x(x_a), .y(y_a)
    );

    ecc_host_ctrl #(.TIMEOUT(32'd50), .CNT_W(32)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_b), .rd_en(rd_b), .addr(addr), .wdata(wdata),
        .rdata(rdata_b), .irq(irq_b), .ecc_op(op_b), .ecc_en(en_b), .ecc_clr(clr_b),
        .in_kr(kr_b), .in_ds(ds_b), .hash_msg(hash_b), .Qx(qx_b), .Qy(qy_b),
        .ecc_rdy(rdy_b), .x(x_b), .y(y_b)
    );

    // Core model: mode 0 never ready, 1 ready from RUN cycle rdy_at onward, 2 always ready
    always @(negedge clk) begin
        if (clr_a)     en_cnt = 0;
        else if (en_a) en_cnt = en_cnt + 1;
        if (en_a)  en_hi_a = en_hi_a + 1;
        if (clr_a) clr_n_a = clr_n_a + 1;
        if (en_b)  en_hi_b = en_hi_b + 1;
        if (clr_b) clr_n_b = clr_n_b + 1;
        rdy_a = (rdy_mode == 2) || ((rdy_mode == 1) && (en_cnt >= rdy_at));
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_en = 1'b1;
        addr  = a;
        wdata = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic bus_rd(input logic [5:0] a, output logic [31:0] d);
        @(negedge clk);
        rd_en = 1'b1;
        addr  = a;
        @(negedge clk);
        rd_en = 1'b0;
        d = rdata_s;
    endtask

    task automatic rd_check(input string tag, input logic [5:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_rd(a, d);
        check(tag, d, exp);
    endtask

    task automatic wait_irq(input string tag, input int limit);
        int n = 0;
        while (!(sel_b ? irq_b : irq_a) && (n < limit)) begin
            @(negedge clk);
            n = n + 1;
        end
        if (n >= limit) check(tag, 1'b0, 1'b1);
    endtask

    task automatic run_op(input string tag, input logic [31:0] ctrl);
        bus_wr(6'h38, ctrl);
        @(negedge clk);
        wait_irq(tag, 400);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [255:0] gx, gy;
        logic [31:0]  d;
        int base_en, base_clr;
        gx = 256'h6B17D1F2_E12C4247_F8BCE6E5_63A440F2_77037D81_2DEB33A0_F4A13945_D898C296;
        gy = 256'h4FE342E2_FE1A7F9B_8EE7EB4A_7C0F9E16_2BCE3357_6B315ECE_CBB64068_37BF51F5;

        repeat (3) @(negedge clk);
        check("rst_en", en_a, 1'b0);
        check("rst_clr", clr_a, 1'b0);
        check("rst_irq", irq_a, 1'b0);
        check("rst_rdata", rdata_a, 32'd0);
        rst_n = 1'b1;
        rd_check("rst_status", 6'h39, 32'd0);

        bus_wr(6'h00, 32'd1);
        for (int i = 0; i < 8; i++) bus_wr(6'h18 + 6'(i), gx[i*32 +: 32]);
        for (int i = 0; i < 8; i++) bus_wr(6'h20 + 6'(i), gy[i*32 +: 32]);
        check("load_kr", kr_a, 256'd1);
        check("load_qx", qx_a, gx);
        check("load_qy", qy_a, gy);
        rd_check("rd_qx7", 6'h1f, 32'h6B17D1F2);

        x_a = {8{32'hAAAAAAAA}};
        y_a = {8{32'h55555555}};
        rdy_mode = 1;
        rdy_at   = 101;
        base_en  = en_hi_a;
        base_clr = clr_n_a;
        bus_wr(6'h38, 32'h1);
        check("lat_clr", clr_a, 1'b1);
        check("lat_en_lo", en_a, 1'b0);
        @(negedge clk);
        check("lat_en_hi", en_a, 1'b1);
        check("lat_clr_lo", clr_a, 1'b0);
        wait_irq("t1_wait", 400);
        check("t1_en_cycles", en_hi_a - base_en, 101);
        check("t1_clr_pulses", clr_n_a - base_clr, 1);
        check("t1_irq", irq_a, 1'b1);
        rd_check("t1_status", 6'h39, 32'h02);
        rd_check("t1_cycles", 6'h3a, 32'd101);
        rd_check("t1_x0", 6'h28, 32'hAAAAAAAA);
        rd_check("t1_x7", 6'h2f, 32'hAAAAAAAA);
        rd_check("t1_y0", 6'h30, 32'h55555555);
        rd_check("t1_y7", 6'h37, 32'h55555555);
        rd_check("ctrl_reads0", 6'h38, 32'd0);
        rd_check("reserved_reads0", 6'h3c, 32'd0);

        rdy_mode = 2;
        base_en  = en_hi_a;
        run_op("t2_wait", 32'h5);
        check("t2_en_cycles", en_hi_a - base_en, 2);
        check("t2_op", op_a, 2'd2);
        rd_check("t2_cycles", 6'h3a, 32'd2);
        rd_check("t2_status", 6'h39, 32'h12);

        rdy_mode = 0;
        bus_wr(6'h38, 32'h3);
        repeat (5) @(negedge clk);
        rd_check("t4_status_busy", 6'h39, 32'h09);
        bus_wr(6'h00, 32'h0000DEAD);
        bus_wr(6'h38, 32'h5);
        rd_check("t5_kr_kept", 6'h00, 32'd1);
        check("t5_op_kept", op_a, 2'd1);
        check("t5_still_run", en_a, 1'b1);
        bus_wr(6'h38, 32'h8);
        check("t4_abort_clr", clr_a, 1'b1);
        check("t4_abort_en", en_a, 1'b0);
        @(negedge clk);
        check("t4_idle_clr", clr_a, 1'b0);
        rd_check("t4_status", 6'h39, 32'h08);
        rd_check("t4_x_kept", 6'h28, 32'hAAAAAAAA);
        check("t4_irq", irq_a, 1'b0);

        rdy_mode = 2;
        run_op("t4_done_wait", 32'h1);
        check("w1c_irq_before", irq_a, 1'b1);
        bus_wr(6'h39, 32'h6);
        @(negedge clk);
        check("w1c_irq_after", irq_a, 1'b0);
        rd_check("w1c_status", 6'h39, 32'h00);

        sel_b    = 1'b1;
        base_en  = en_hi_b;
        base_clr = clr_n_b;
        run_op("t3_wait", 32'h1);
        check("t3_en_cycles", en_hi_b - base_en, 50);
        check("t3_clr_pulses", clr_n_b - base_clr, 2);
        check("t3_irq", irq_b, 1'b1);
        rd_check("t3_status", 6'h39, 32'h04);
        rd_check("t3_cycles", 6'h3a, 32'd50);
        rd_check("t3_x_kept", 6'h28, 32'd0);
        rd_check("t3_y_kept", 6'h37, 32'd0);
        sel_b = 1'b0;

        rdy_mode = 0;
        bus_wr(6'h38, 32'h1);
        repeat (5) @(negedge clk);
        bus_rd(6'h28, d);
        check("t6_pre_rdata", d, 32'hAAAAAAAA);
        check("t6_pre_en", en_a, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_en", en_a, 1'b0);
        check("t6_rst_clr", clr_a, 1'b0);
        check("t6_rst_rdata", rdata_a, 32'd0);
        check("t6_rst_irq", irq_a, 1'b0);
        check("t6_rst_kr", kr_a, 256'd0);
        check("t6_rst_qx", qx_a, 256'd0);
        check("t6_rst_op", op_a, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_check("t6_rst_x", 6'h28, 32'd0);

        x_a      = {8{32'h12345678}};
        rdy_mode = 1;
        rdy_at   = 3;
        run_op("t6_wait", 32'h7);
        rd_check("t6_cycles", 6'h3a, 32'd3);
        rd_check("t6_status", 6'h39, 32'h1A);
        rd_check("t6_x", 6'h2b, 32'h12345678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
